led_pwm_array: RTL
==================

Name: led_pwm_array

Overview:
- Parametrised multi-channel successor to the single-channel 12-bit LED PWM controller.
- One shared free-running frame counter drives N_CH compare channels.
- Each channel has a double-buffered duty register: host writes go to a shadow bank and are committed to the active bank only at a frame boundary, so no frame tears.
- Sits between the frame-data loader and the LED driver pads.

Parameters:
- WIDTH, 12, counter/duty width; frame length 2^WIDTH clocks
- N_CH, 8, number of LED channels (1..64)
- CH_W, $clog2(N_CH) (min 1), channel-select width (derived, not overridden)

Ports:
- oscillator  in  1  single clock, all logic on rising edge
- globalReset  in  1  synchronous, active-high reset
- enable  in  1  counter runs when high; holds when low
- wr_valid  in  1  shadow write request
- wr_ready  out  1  shadow write accepted when wr_valid & wr_ready
- wr_chan  in  CH_W  target channel
- wr_duty  in  WIDTH  duty value
- commit  in  1  one-cycle pulse: transfer shadow to active at next frame boundary
- commit_pending  out  1  commit armed, not yet applied
- frame_start  out  1  one-cycle pulse when counter is 0
- power  out  N_CH  PWM outputs, registered

Behaviour:
- Reset (globalReset high at an edge): cnt=0, all shadow=0, all active=0, power=0, frame_start=0, commit_pending=0, wr_ready=1. Reset mid-frame aborts the frame; a pending commit is discarded.
- Counter: cnt increments by 1 per clock when enable=1; wraps from 2^WIDTH-1 to 0; holds when enable=0.
- frame_start: registered. It is 1 in the cycle after the cycle in which cnt==0 and enable=1.
- Compare, per channel i, evaluated on the current cnt and registered into power[i] (1-cycle latency):
  - active[i]==0: power[i]=0.
  - active[i]==all-ones: power[i]=1 for the whole frame (full on; 2^W-1 is reserved for this).
  - otherwise: power[i] = (cnt < active[i]), unsigned compare.
- enable=0: power holds its last value.
- Write handshake: wr_ready = ~commit_pending. On wr_valid & wr_ready, shadow[wr_chan] <= wr_duty. Writes with wr_chan >= N_CH are accepted and dropped.
- Commit:
  - commit=1 sets commit_pending.
  - At the edge where cnt wraps 2^WIDTH-1 -> 0 with enable=1 and commit_pending=1: all active <= shadow, and commit_pending clears.
  - The new duties take effect from compare of cnt=0 onward.
  - commit while already pending has no further effect.
  - commit in the same cycle as the wrap edge arms for the next wrap, not the current one.
- Write and commit in the same cycle: the write is accepted (wr_ready was 1) and is included in the commit.
- Write blocked while pending: the host must wait for commit_pending to fall.

Optional Feature:
- Macro: LED_PWM_STAGGER_EN.
- Defined: channel i compares against phase-shifted count pc_i = (cnt - i*(2^WIDTH / N_CH)) mod 2^WIDTH, using integer division. This spreads turn-on edges to cut supply inrush. The 0 and all-ones rules are unchanged.
- Not defined: all channels use cnt directly, so all turn on together at cnt=0.
- Ports, latency and commit timing are identical in both builds.

Decomposition:
- Package led_pwm_pkg: duty-encoding constants DUTY_OFF (0) and DUTY_FULL (all-ones) as WIDTH-parametric functions, and a phase-offset function used under LED_PWM_STAGGER_EN.
- Sub-module led_pwm_channel: shadow/active pair plus compare and output register, instantiated N_CH times via generate.
- Counter, commit control and write decode live in the top module.

Test Plan (WIDTH=4, N_CH=4 unless stated):
- Reset then enable=1, no writes -> power=0 for 32 cycles; frame_start pulses every 16 cycles.
- Write ch1=5, commit at cnt=3 -> commit_pending=1 and wr_ready=0 until wrap; from the next frame, power[1] is high for exactly 5 cycles per frame, 1 cycle after cnt=0..4.
- Write ch2=15 (full) and ch3=0, commit -> after boundary power[2]=1 continuously and power[3]=0 continuously; the old frame is unaffected before the boundary.
- commit asserted on the exact wrap cycle -> applied one frame later (after 16 more cycles), not immediately.
- globalReset mid-frame with commit pending -> all outputs return to reset values next cycle; the shadowed value never reaches active.
- LED_PWM_STAGGER_EN defined, all channels duty=4 -> power[i] rises at cnt = 4*i (+1 cycle latency); each channel is high for 4 cycles.

Source files
------------

// File: rtl/led_pwm_pkg.sv
// rtl/led_pwm_pkg.sv - duty encoding constants and stagger phase helper for led_pwm_array
package led_pwm_pkg;

    // All-ones duty is reserved for "full on"; returned wide and truncated by the caller.
    function automatic logic [63:0] duty_full(input int unsigned w);
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic logic [63:0] duty_off(input int unsigned w);
        return duty_full(w) & 64'd0;
    endfunction

    // Start-of-high offset for channel i when turn-on edges are spread across the frame.
    function automatic int unsigned phase_offset(input int unsigned w,
                                                 input int unsigned n,
                                                 input int unsigned i);
        return i * ((32'd1 << w) / n);
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// rtl/led_pwm_channel.sv - one PWM channel: shadow/active duty pair, compare and output register
module led_pwm_channel
    import led_pwm_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int PHASE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_duty,
    input  logic             load,
    input  logic [WIDTH-1:0] cnt,
    output logic             power
);

    localparam logic [WIDTH-1:0] D_OFF  = WIDTH'(duty_off(WIDTH));
    localparam logic [WIDTH-1:0] D_FULL = WIDTH'(duty_full(WIDTH));
    localparam logic [WIDTH-1:0] PH     = WIDTH'(PHASE);

    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] active;
    logic [WIDTH-1:0] pc;
    logic             hit;

    // Modular subtraction wraps naturally; PHASE of 0 gives the unstaggered count.
    assign pc = cnt - PH;

    always_comb begin
        hit = 1'b0;
        if (active == D_OFF)
            hit = 1'b0;
        else if (active == D_FULL)
            hit = 1'b1;
        else
            hit = (pc < active);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            active <= '0;
            power  <= 1'b0;
        end else begin
            if (wr_en)
                shadow <= wr_duty;
            if (load)
                active <= shadow;
            if (enable)
                power <= hit;
        end
    end

endmodule

// File: rtl/led_pwm_array.sv
// rtl/led_pwm_array.sv - N_CH PWM array, shared frame counter, frame-aligned commit; LED_PWM_STAGGER_EN phase-shifts channels
module led_pwm_array
    import led_pwm_pkg::*;
#(
    parameter  int WIDTH = 12,
    parameter  int N_CH  = 8,
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             oscillator,
    input  logic             globalReset,
    input  logic             enable,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [CH_W-1:0]  wr_chan,
    input  logic [WIDTH-1:0] wr_duty,
    input  logic             commit,
    output logic             commit_pending,
    output logic             frame_start,
    output logic [N_CH-1:0]  power
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(duty_full(WIDTH));

    logic [WIDTH-1:0] cnt;
    logic             wrap;
    logic             apply;
    logic             wr_fire;

    assign wrap     = enable && (cnt == CNT_MAX);
    assign apply    = wrap && commit_pending;
    assign wr_ready = ~commit_pending;
    assign wr_fire  = wr_valid && wr_ready;

    always_ff @(posedge oscillator) begin
        if (globalReset) begin
            cnt         <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= enable && (cnt == '0);
            if (enable)
                cnt <= cnt + 1'b1;
        end
    end

    // A commit landing on the applying edge (or while armed) does not re-arm.
    always_ff @(posedge oscillator) begin
        if (globalReset)
            commit_pending <= 1'b0;
        else if (apply)
            commit_pending <= 1'b0;
        else if (commit)
            commit_pending <= 1'b1;
    end

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
`ifdef LED_PWM_STAGGER_EN
        localparam int PHASE = int'(phase_offset(WIDTH, N_CH, ch));
`else
        localparam int PHASE = 0;
`endif
        logic wr_en;

        // Channels beyond N_CH never match, so such writes are dropped.
        assign wr_en = wr_fire && (wr_chan == CH_W'(ch));

        led_pwm_channel #(
            .WIDTH (WIDTH),
            .PHASE (PHASE)
        ) u_ch (
            .clk     (oscillator),
            .rst     (globalReset),
            .enable  (enable),
            .wr_en   (wr_en),
            .wr_duty (wr_duty),
            .load    (apply),
            .cnt     (cnt),
            .power   (power[ch])
        );
    end

endmodule
